// File: rtl/rom_loader_if.sv
// Byte-stream handshake between the program source and the ROM loader.
// master drives valid/byte/last; slave drives ready.
interface rom_loader_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_byte,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/rom_loader.sv
// Fills a 2**ADDR_W byte instruction ROM from a valid/ready byte stream.
// Ports: clk, reset_n (sync, active-low), start, s_in (byte stream),
// busy/done/overflow (state decodes), count, A/I (big-endian word read).
module rom_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  rom_loader_if.slave       s_in,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] I
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_count;
  logic [7:0]          r_mem [DEPTH];

  logic w_xfer;
  logic w_restart;
  logic w_at_end;

  assign w_xfer    = s_in.in_valid && (r_state == S_LOAD);
  assign w_at_end  = (r_wr_ptr == ADDR_W'(DEPTH - 1));
  // start only restarts outside LOAD
  assign w_restart = start && (r_state != S_LOAD);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_xfer) begin
          if (s_in.in_last)  w_next = S_DONE;
          else if (w_at_end) w_next = S_ERR;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (w_xfer) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end
    end
  end

  // Memory is deliberately outside reset so a reset keeps the image.
  always_ff @(posedge clk) begin
    if (reset_n && w_xfer) begin
      r_mem[r_wr_ptr] <= s_in.in_byte;
    end
  end

  assign s_in.in_ready = (r_state == S_LOAD);
  assign busy          = (r_state == S_LOAD);
  assign done          = (r_state == S_DONE);
  assign overflow      = (r_state == S_ERR);
  assign count         = r_count;

  // Byte k of the word comes from A+k, wrapping modulo DEPTH.
  for (genvar k = 0; k < NB; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = A + ADDR_W'(k);
    assign I[DATA_W-1-8*k -: 8] = r_mem[w_addr];
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed testbench for rom_loader.
// Drives the byte stream through the interface and checks outputs.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [9:0]  count;
  logic [8:0]  A;
  logic [31:0] I;

  int n_chk = 0;
  int n_err = 0;

  rom_loader_if bus ();

  rom_loader #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .s_in     (bus.slave),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .count    (count),
    .A        (A),
    .I        (I)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [8:0] a,
                    input logic [31:0] exp);
    A = a;
    #1;
    chk(tag, I, exp);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_last  = 1'b0;
    A            = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_cnt", {22'd0, count}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: 16 bytes 00..0F
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_rdy", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), i == 15);
      if (i == 3) rd("t1_wlat", 9'd0, 32'h00010203);
    end
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy0", {31'd0, busy}, 32'd0);
    chk("t1_cnt", {22'd0, count}, 32'd16);
    rd("t1_a0", 9'd0, 32'h00010203);
    rd("t1_a12", 9'd12, 32'h0C0D0E0F);

    // 2: 8-byte image with random gaps
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      while ($urandom_range(0, 1) == 0) begin
        tick();
        chk("t2_rdy_gap", {31'd0, bus.in_ready}, 32'd1);
      end
      send(8'hA0 + 8'(i), i == 7);
    end
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_rdy0", {31'd0, bus.in_ready}, 32'd0);
    chk("t2_cnt", {22'd0, count}, 32'd8);
    rd("t2_a0", 9'd0, 32'hA0A1A2A3);
    rd("t2_a4", 9'd4, 32'hA4A5A6A7);
    rd("t2_a8", 9'd8, 32'h08090A0B);

    // 3 + 5: full 512-byte image
    pulse_start();
    for (int i = 0; i < 512; i++) send(8'(i), i == 511);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_ovf", {31'd0, overflow}, 32'd0);
    chk("t3_cnt", {22'd0, count}, 32'd512);
    rd("t3_a508", 9'd508, 32'hFCFDFEFF);
    rd("t5_wrap", 9'd510, 32'hFEFF0001);

    // 4: overflow; also start+transfer and idle start in LOAD
    pulse_start();
    start = 1'b1;
    send(8'h11, 1'b0);
    start = 1'b0;
    chk("t4_xfer_start", {22'd0, count}, 32'd1);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    pulse_start();
    chk("t4_ign_start", {22'd0, count}, 32'd3);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    for (int i = 3; i < 512; i++) send(8'h11 + 8'(i), 1'b0);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    chk("t4_rdy0", {31'd0, bus.in_ready}, 32'd0);
    chk("t4_cnt", {22'd0, count}, 32'd512);
    send(8'h77, 1'b0);
    send(8'h78, 1'b1);
    chk("t4_cnt_hold", {22'd0, count}, 32'd512);
    chk("t4_ovf_hold", {31'd0, overflow}, 32'd1);
    rd("t4_mem0", 9'd0, 32'h11121314);

    // 6: reset mid-load, then reload
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_rst_cnt", {22'd0, count}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    rd("t6_keep", 9'd0, 32'h50515253);
    pulse_start();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk("t6_cnt", {22'd0, count}, 32'd2);
    chk("t6_done", {31'd0, done}, 32'd1);
    rd("t6_a0", 9'd0, 32'hAABB5253);
    rd("t6_a1", 9'd1, 32'hBB525354);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
